vscale_htif_pcr_host: RTL and testbench

//  Host-side initiator for the HTIF PCR channel. It takes one CSR read/write command from a testbench or debug controller,

---
 rtl/vscale_htif_pcr_host_pkg.sv | 23 ++
 rtl/vscale_htif_pcr_host_timeout.sv | 30 +++
 rtl/vscale_htif_pcr_host.sv | 133 +++++++++++++
 tb/tb_vscale_htif_pcr_host.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_htif_pcr_host_pkg.sv
// Shared constants and types for the HTIF PCR host initiator.
// Holds the CSR/PCR widths, the 2-bit state encodings and the timeout error data word.
package vscale_htif_pcr_host_pkg;

  localparam int CSR_ADDR_WIDTH = 12;
  localparam int HTIF_PCR_WIDTH = 32;

  typedef enum logic [1:0] {
    HTIF_HOST_IDLE = 2'd0,
    HTIF_HOST_REQ  = 2'd1,
    HTIF_HOST_WAIT = 2'd2,
    HTIF_HOST_DONE = 2'd3
  } htif_host_state_t;

  localparam logic [HTIF_PCR_WIDTH-1:0] HTIF_HOST_ERR_DATA = '1;

  typedef struct packed {
    logic                      rw;
    logic [CSR_ADDR_WIDTH-1:0] addr;
    logic [HTIF_PCR_WIDTH-1:0] data;
  } pcr_req_t;

endpackage

// File: rtl/vscale_htif_pcr_host_timeout.sv
// Response timeout counter: cleared on entry to WAIT, counts WAIT cycles.
// expire is high on the last allowed WAIT cycle (count == TIMEOUT_CYCLES-1).
module vscale_htif_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  assign expire = enable && (count_reg == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expire) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/vscale_htif_pcr_host.sv
// Host-side requester for the HTIF PCR channel: one CSR command in flight at a time.
// Define VSCALE_HTIF_HOST_TIMEOUT_EN to compile in the response timeout and stale-response drain.
module vscale_htif_pcr_host
  import vscale_htif_pcr_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rw,
  input  logic [CSR_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [HTIF_PCR_WIDTH-1:0] cmd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [HTIF_PCR_WIDTH-1:0] rsp_data,
  output logic                      rsp_err,
  output logic                      pcr_req_valid,
  input  logic                      pcr_req_ready,
  output logic                      pcr_req_rw,
  output logic [CSR_ADDR_WIDTH-1:0] pcr_req_addr,
  output logic [HTIF_PCR_WIDTH-1:0] pcr_req_data,
  input  logic                      pcr_resp_valid,
  output logic                      pcr_resp_ready,
  input  logic [HTIF_PCR_WIDTH-1:0] pcr_resp_data,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      txn_count
);

  htif_host_state_t          state_reg, state_next;
  pcr_req_t                  req_reg;
  logic [HTIF_PCR_WIDTH-1:0] rsp_data_reg;
  logic [CNT_WIDTH-1:0]      txn_count_reg;
  logic                      drain;
  logic                      timeout_expire;

  logic cmd_fire, req_fire, resp_accept, rsp_fire, timeout_fire;

`ifdef VSCALE_HTIF_HOST_TIMEOUT_EN
  logic drain_reg;
  logic rsp_err_reg;

  vscale_htif_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (req_fire),
    .enable (state_reg == HTIF_HOST_WAIT),
    .expire (timeout_expire)
  );

  assign drain   = drain_reg;
  assign rsp_err = rsp_err_reg;

  // A response on the expiry cycle wins, so the timeout only fires without one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_reg   <= 1'b0;
      rsp_err_reg <= 1'b0;
    end else begin
      if (timeout_fire) begin
        drain_reg <= 1'b1;
      end else if (drain_reg && pcr_resp_valid) begin
        drain_reg <= 1'b0;
      end
      if (resp_accept) begin
        rsp_err_reg <= 1'b0;
      end else if (timeout_fire) begin
        rsp_err_reg <= 1'b1;
      end
    end
  end
`else
  assign timeout_expire = 1'b0;
  assign drain          = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  assign cmd_ready      = (state_reg == HTIF_HOST_IDLE) && !drain;
  assign pcr_req_valid  = (state_reg == HTIF_HOST_REQ);
  assign pcr_resp_ready = (state_reg == HTIF_HOST_WAIT) || drain;
  assign rsp_valid      = (state_reg == HTIF_HOST_DONE);
  assign busy           = (state_reg != HTIF_HOST_IDLE) || drain;

  assign pcr_req_rw   = req_reg.rw;
  assign pcr_req_addr = req_reg.addr;
  assign pcr_req_data = req_reg.data;
  assign rsp_data     = rsp_data_reg;
  assign txn_count    = txn_count_reg;

  assign cmd_fire     = cmd_valid && cmd_ready;
  assign req_fire     = pcr_req_valid && pcr_req_ready;
  assign resp_accept  = (state_reg == HTIF_HOST_WAIT) && pcr_resp_valid;
  assign timeout_fire = (state_reg == HTIF_HOST_WAIT) && !pcr_resp_valid && timeout_expire;
  assign rsp_fire     = rsp_valid && rsp_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HTIF_HOST_IDLE: if (cmd_fire) state_next = HTIF_HOST_REQ;
      HTIF_HOST_REQ:  if (pcr_req_ready) state_next = HTIF_HOST_WAIT;
      HTIF_HOST_WAIT: if (resp_accept || timeout_fire) state_next = HTIF_HOST_DONE;
      HTIF_HOST_DONE: if (rsp_ready) state_next = HTIF_HOST_IDLE;
      default:        state_next = HTIF_HOST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= HTIF_HOST_IDLE;
      req_reg       <= '0;
      rsp_data_reg  <= '0;
      txn_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (cmd_fire) begin
        req_reg <= '{rw: cmd_rw, addr: cmd_addr, data: cmd_data};
      end
      if (resp_accept) begin
        rsp_data_reg <= pcr_resp_data;
      end else if (timeout_fire) begin
        rsp_data_reg <= HTIF_HOST_ERR_DATA;
      end
      if (rsp_fire) begin
        txn_count_reg <= txn_count_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vscale_htif_pcr_host.sv
// Self-checking bench for vscale_htif_pcr_host with a CSR-memory model of the core side.
// Timeout scenarios run only when VSCALE_HTIF_HOST_TIMEOUT_EN is defined.
module tb_vscale_htif_pcr_host;
  import vscale_htif_pcr_host_pkg::*;

  localparam int TO = 8;
  localparam int CW = 8;
  localparam int AW = CSR_ADDR_WIDTH;
  localparam int DW = HTIF_PCR_WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          pcr_req_valid, pcr_req_ready = 1'b0, pcr_req_rw;
  logic [AW-1:0] pcr_req_addr;
  logic [DW-1:0] pcr_req_data;
  logic          pcr_resp_valid = 1'b0, pcr_resp_ready;
  logic [DW-1:0] pcr_resp_data = '0;
  logic          busy;
  logic [CW-1:0] txn_count;

  int            tests = 0;
  int            fails = 0;
  int            hs_count = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [DW-1:0] csr_mem [1<<AW];

  vscale_htif_pcr_host #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .pcr_req_valid(pcr_req_valid), .pcr_req_ready(pcr_req_ready), .pcr_req_rw(pcr_req_rw),
    .pcr_req_addr(pcr_req_addr), .pcr_req_data(pcr_req_data),
    .pcr_resp_valid(pcr_resp_valid), .pcr_resp_ready(pcr_resp_ready),
    .pcr_resp_data(pcr_resp_data),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!reset && pcr_req_valid && pcr_req_ready) hs_count++;

  // One complete command; the core side answers from csr_mem (old value on writes).
  task automatic do_txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int req_delay, input int resp_delay, input int rsp_hold,
                        input string tag);
    logic [DW-1:0] exp_rsp;
    int hs0;
    exp_rsp = csr_mem[addr];
    if (rw) csr_mem[addr] = data;
    hs0 = hs_count;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s cmd_ready got %b exp 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_rw = ~rw; cmd_addr = ~addr; cmd_data = $urandom;
    for (int i = 0; i <= req_delay; i++) begin
      tests++;
      if ({pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data} !== {1'b1, rw, addr, data}) begin
        fails++;
        $display("FAIL %s req_fields cyc %0d got %b/%b/%h/%h exp 1/%b/%h/%h", tag, i,
                 pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data, rw, addr, data);
      end
      if (i == req_delay) pcr_req_ready = 1'b1;
      @(negedge clk);
    end
    pcr_req_ready = 1'b0;
    for (int i = 0; i < resp_delay; i++) begin
      tests++;
      if (pcr_resp_ready !== 1'b1 || rsp_valid !== 1'b0 || pcr_req_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s wait cyc %0d resp_ready %b rsp_valid %b req_valid %b exp 1/0/0",
                 tag, i, pcr_resp_ready, rsp_valid, pcr_req_valid);
      end
      @(negedge clk);
    end
    tests++;
    if (pcr_resp_ready !== 1'b1) begin
      fails++; $display("FAIL %s resp_ready got %b exp 1", tag, pcr_resp_ready);
    end
    pcr_resp_valid = 1'b1; pcr_resp_data = exp_rsp;
    @(negedge clk);
    pcr_resp_valid = 1'b0; pcr_resp_data = $urandom;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_rsp || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL %s result got v=%b d=%h e=%b exp v=1 d=%h e=0", tag, rsp_valid, rsp_data, rsp_err, exp_rsp);
    end
    for (int i = 0; i < rsp_hold; i++) begin
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = $urandom; cmd_data = $urandom;
      tests++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== exp_rsp) begin
        fails++;
        $display("FAIL %s hold cyc %0d cmd_ready %b rsp_valid %b rsp_data %h exp 0/1/%h",
                 tag, i, cmd_ready, rsp_valid, rsp_data, exp_rsp);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    tests++;
    if (txn_count !== exp_cnt || busy !== 1'b0 || cmd_ready !== 1'b1 || hs_count - hs0 != 1) begin
      fails++;
      $display("FAIL %s after count %0d busy %b cmd_ready %b handshakes %0d exp %0d/0/1/1",
               tag, txn_count, busy, cmd_ready, hs_count - hs0, exp_cnt);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_data, rsp_err, pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data,
         pcr_resp_ready, busy, txn_count} !== '0) begin
      fails++;
      $display("FAIL reset_state rsp_v %b d %h e %b req_v %b addr %h busy %b cnt %0d exp all 0",
               rsp_valid, rsp_data, rsp_err, pcr_req_valid, pcr_req_addr, busy, txn_count);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    csr_mem[12'h50D] = 32'hDEAD_BEEF;
    do_txn(1'b0, 12'h50D, 32'h0, 0, 0, 0, "read_50d");
    tests++;
    if (txn_count !== CW'(1)) begin
      fails++; $display("FAIL read_count got %0d exp 1", txn_count);
    end
  endtask

  task automatic test_write_backpressure();
    do_txn(1'b1, 12'h123, 32'hCAFE_F00D, 5, 1, 0, "write_bp");
    do_txn(1'b0, 12'h123, 32'h0, 0, 0, 0, "readback");
  endtask

  task automatic test_rsp_hold();
    do_txn(1'b0, 12'h7C0, 32'h0, 0, 2, 10, "rsp_hold");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
  endtask

`ifdef VSCALE_HTIF_HOST_TIMEOUT_EN
  task automatic test_timeout();
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL to_start cmd_ready got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h0AA;
    @(negedge clk);
    cmd_valid = 1'b0; pcr_req_ready = 1'b1;
    @(negedge clk);
    pcr_req_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      tests++;
      if (rsp_valid !== 1'b0) begin
        fails++; $display("FAIL to_early cyc %0d rsp_valid got %b exp 0", i, rsp_valid);
      end
      @(negedge clk);
    end
    tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '1) begin
      fails++; $display("FAIL to_result v %b e %b d %h exp 1/1/ffffffff", rsp_valid, rsp_err, rsp_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    tests++;
    if (txn_count !== exp_cnt || cmd_ready !== 1'b0 || busy !== 1'b1 || pcr_resp_ready !== 1'b1) begin
      fails++;
      $display("FAIL to_drain cnt %0d cmd_ready %b busy %b resp_ready %b exp %0d/0/1/1",
               txn_count, cmd_ready, busy, pcr_resp_ready, exp_cnt);
    end
    cmd_valid = 1'b1; cmd_addr = 12'h001;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b0 || pcr_req_valid !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL to_blocked cmd_ready %b req_valid %b busy %b exp 0/0/1",
                          cmd_ready, pcr_req_valid, busy);
      end
    end
    pcr_resp_valid = 1'b1; pcr_resp_data = 32'h5A5A_5A5A;
    @(negedge clk);
    pcr_resp_valid = 1'b0; cmd_valid = 1'b0;
    tests++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || pcr_req_valid !== 1'b0) begin
      fails++; $display("FAIL to_drained busy %b cmd_ready %b rsp_valid %b req_valid %b exp 0/1/0/0",
                        busy, cmd_ready, rsp_valid, pcr_req_valid);
    end
    csr_mem[12'h0AB] = 32'h1357_9BDF;
    do_txn(1'b0, 12'h0AB, 32'h0, 0, 0, 0, "after_drain");
    do_txn(1'b1, 12'h0AC, 32'h2468_ACE0, 0, TO - 1, 0, "to_boundary");
  endtask
`endif

  task automatic test_reset_in_wait();
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h3FF;
    @(negedge clk);
    cmd_valid = 1'b0; pcr_req_ready = 1'b1;
    @(negedge clk);
    pcr_req_ready = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({rsp_valid, rsp_data, rsp_err, pcr_req_valid, pcr_req_addr, pcr_resp_ready, busy, txn_count} !== '0) begin
      fails++;
      $display("FAIL async_reset rsp_v %b d %h req_v %b addr %h resp_ready %b busy %b cnt %0d exp all 0",
               rsp_valid, rsp_data, pcr_req_valid, pcr_req_addr, pcr_resp_ready, busy, txn_count);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0;
    pcr_resp_valid = 1'b1; pcr_resp_data = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0 || pcr_resp_ready !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL post_reset rsp_valid %b resp_ready %b busy %b exp 0/0/0",
                          rsp_valid, pcr_resp_ready, busy);
      end
    end
    pcr_resp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back_wrap();
    for (int n = 0; n < (1 << CW) + 1; n++) begin
      do_txn(1'b0, AW'($urandom_range(16, 31)), 32'h0, 0, 0, 0, "b2b");
    end
    tests++;
    if (txn_count !== CW'(1)) begin
      fails++; $display("FAIL wrap_count got %0d exp 1", txn_count);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) csr_mem[i] = $urandom;
    test_reset();
    test_read();
    test_write_backpressure();
    test_rsp_hold();
    test_random();
`ifdef VSCALE_HTIF_HOST_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    test_back_to_back_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
